// File: rtl/robot_pose_if.sv
// Command, load and pose bundle between the navigation controller / map logic
// and the robot pose engine.
interface robot_pose_if #(
   parameter int CNT_W = 16
);
   logic             cmd_valid;
   logic [1:0]       cmd;
   logic             cmd_ready;
   logic             wall_ahead;
   logic             load_valid;
   logic [5:0]       load_row;
   logic [5:0]       load_col;
   logic [1:0]       load_dir;
   logic [5:0]       robot_row;
   logic [5:0]       robot_column;
   logic [1:0]       robot_orientation;
   logic             front_blocked;
   logic             bump;
   logic [CNT_W-1:0] move_count;
   logic             anomaly;

   modport master (
      output cmd_valid, cmd, wall_ahead, load_valid, load_row, load_col, load_dir,
      input  cmd_ready, robot_row, robot_column, robot_orientation,
             front_blocked, bump, move_count, anomaly
   );

   modport slave (
      input  cmd_valid, cmd, wall_ahead, load_valid, load_row, load_col, load_dir,
      output cmd_ready, robot_row, robot_column, robot_orientation,
             front_blocked, bump, move_count, anomaly
   );
endinterface

// File: rtl/robot_pose_engine.sv
// Robot pose engine: executes hold/forward/turn commands one at a time with a
// programmable post-command wait, blocks moves into borders/walls, accepts pose loads.
module robot_pose_engine #(
   parameter int         ROWS       = 10,
   parameter int         COLS       = 20,
   parameter int         MOVE_TICKS = 3,
   parameter int         START_ROW  = 1,
   parameter int         START_COL  = 1,
   parameter logic [1:0] START_DIR  = 2'b00,
   parameter int         CNT_W      = 16
) (
   input logic         clock_50,
   input logic         reset_key,
   robot_pose_if.slave pif
);
   typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, WAIT = 2'b10} state_t;

   localparam logic [1:0] DIR_N = 2'b00;
   localparam logic [1:0] DIR_S = 2'b01;
   localparam logic [1:0] DIR_E = 2'b10;
   localparam logic [1:0] DIR_W = 2'b11;
   localparam logic [1:0] CMD_FWD   = 2'b01;
   localparam logic [1:0] CMD_LEFT  = 2'b10;
   localparam logic [1:0] CMD_RIGHT = 2'b11;

   // The wait counter counts MOVE_TICKS-1 down to zero; keep at least one bit.
   localparam int TW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
   localparam logic [TW-1:0] WAIT_LOAD = (MOVE_TICKS > 0) ? TW'(MOVE_TICKS - 1) : {TW{1'b0}};

   function automatic logic [1:0] turn_left(input logic [1:0] d);
      case (d)
         DIR_N:   return DIR_W;
         DIR_W:   return DIR_S;
         DIR_S:   return DIR_E;
         DIR_E:   return DIR_N;
         default: return DIR_N;
      endcase
   endfunction

   function automatic logic [1:0] turn_right(input logic [1:0] d);
      case (d)
         DIR_N:   return DIR_E;
         DIR_E:   return DIR_S;
         DIR_S:   return DIR_W;
         DIR_W:   return DIR_N;
         default: return DIR_N;
      endcase
   endfunction

   state_t           state_r, state_s;
   logic [1:0]       cmd_r, cmd_s;
   logic [TW-1:0]    cnt_r, cnt_s;
   logic [5:0]       row_r, row_s, col_r, col_s;
   logic [1:0]       dir_r, dir_s;
   logic             bump_r, bump_s;
   logic [CNT_W-1:0] count_r, count_s;
   logic             anomaly_r, anomaly_s;
   logic             front_blocked_s, load_legal_s;

   assign front_blocked_s = ((dir_r == DIR_N) && (row_r == 6'd1))
                         || ((dir_r == DIR_S) && (row_r == 6'(ROWS)))
                         || ((dir_r == DIR_E) && (col_r == 6'(COLS)))
                         || ((dir_r == DIR_W) && (col_r == 6'd1))
                         || pif.wall_ahead;

   assign load_legal_s = (pif.load_row >= 6'd1) && (pif.load_row <= 6'(ROWS))
                      && (pif.load_col >= 6'd1) && (pif.load_col <= 6'(COLS));

   // Next-state and datapath: loads win over commands, commands apply at the end of EXEC.
   always_comb begin
      state_s   = state_r;
      cmd_s     = cmd_r;
      cnt_s     = cnt_r;
      row_s     = row_r;
      col_s     = col_r;
      dir_s     = dir_r;
      bump_s    = 1'b0;
      count_s   = count_r;
      anomaly_s = anomaly_r;
      case (state_r)
         IDLE: begin
            if (pif.load_valid) begin
               if (load_legal_s) begin
                  row_s = pif.load_row;
                  col_s = pif.load_col;
                  dir_s = pif.load_dir;
               end else begin
                  anomaly_s = 1'b1;
               end
            end else if (pif.cmd_valid) begin
               cmd_s   = pif.cmd;
               state_s = EXEC;
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: begin
            case (cmd_r)
               CMD_FWD: begin
                  if (front_blocked_s) begin
                     bump_s = 1'b1;
                  end else begin
                     case (dir_r)
                        DIR_N:   row_s = row_r - 6'd1;
                        DIR_S:   row_s = row_r + 6'd1;
                        DIR_E:   col_s = col_r + 6'd1;
                        DIR_W:   col_s = col_r - 6'd1;
                        default: row_s = row_r;
                     endcase
                     if (count_r != {CNT_W{1'b1}}) begin
                        count_s = count_r + CNT_W'(1'b1);
                     end else begin
                        count_s = count_r;
                     end
                  end
               end
               CMD_LEFT:  dir_s = turn_left(dir_r);
               CMD_RIGHT: dir_s = turn_right(dir_r);
               default:   dir_s = dir_r;
            endcase
            if (MOVE_TICKS > 0) begin
               state_s = WAIT;
               cnt_s   = WAIT_LOAD;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == {TW{1'b0}}) begin
               state_s = IDLE;
            end else begin
               cnt_s = cnt_r - TW'(1'b1);
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State and pose registers; reset drops any latched command.
   always_ff @(posedge clock_50 or posedge reset_key) begin
      if (reset_key) begin
         state_r   <= IDLE;
         cmd_r     <= 2'b00;
         cnt_r     <= {TW{1'b0}};
         row_r     <= 6'(START_ROW);
         col_r     <= 6'(START_COL);
         dir_r     <= START_DIR;
         bump_r    <= 1'b0;
         count_r   <= {CNT_W{1'b0}};
         anomaly_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         cmd_r     <= cmd_s;
         cnt_r     <= cnt_s;
         row_r     <= row_s;
         col_r     <= col_s;
         dir_r     <= dir_s;
         bump_r    <= bump_s;
         count_r   <= count_s;
         anomaly_r <= anomaly_s;
      end
   end

   assign pif.cmd_ready         = (state_r == IDLE) && !pif.load_valid;
   assign pif.front_blocked     = front_blocked_s;
   assign pif.robot_row         = row_r;
   assign pif.robot_column      = col_r;
   assign pif.robot_orientation = dir_r;
   assign pif.bump              = bump_r;
   assign pif.move_count        = count_r;
   assign pif.anomaly           = anomaly_r;
endmodule

// File: tb/tb_robot_pose_engine.sv
// Directed and randomized bench for robot_pose_engine against a transaction-level pose model.
module tb_robot_pose_engine;
   localparam int ROWS = 10, COLS = 20, MOVE_TICKS = 3, CNT_W = 16;

   logic clock_50 = 1'b0;
   logic reset_key;

   robot_pose_if #(.CNT_W(CNT_W)) pif();

   robot_pose_engine #(
      .ROWS(ROWS), .COLS(COLS), .MOVE_TICKS(MOVE_TICKS),
      .START_ROW(1), .START_COL(1), .START_DIR(2'b00), .CNT_W(CNT_W)
   ) dut (
      .clock_50(clock_50),
      .reset_key(reset_key),
      .pif(pif)
   );

   always #5 clock_50 = ~clock_50;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: pose, counters, and how many cycles the engine stays busy.
   int         m_row, m_col, m_cnt, m_busy;
   logic [1:0] m_dir, m_pcmd;
   bit         m_anom, m_bump, m_pend;
   logic [1:0] compass [4] = '{2'b00, 2'b10, 2'b01, 2'b11};  // N E S W clockwise

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int cidx(input logic [1:0] d);
      for (int i = 0; i < 4; i++) if (compass[i] == d) return i;
      return 0;
   endfunction

   function automatic bit m_fb();
      return (m_dir == 2'b00 && m_row == 1) || (m_dir == 2'b01 && m_row == ROWS) ||
             (m_dir == 2'b10 && m_col == COLS) || (m_dir == 2'b11 && m_col == 1) ||
             (pif.wall_ahead === 1'b1);
   endfunction

   task automatic model_reset();
      m_row = 1; m_col = 1; m_dir = 2'b00; m_cnt = 0;
      m_anom = 0; m_bump = 0; m_pend = 0; m_busy = 0; m_pcmd = 2'b00;
   endtask

   task automatic model_edge();
      if (m_pend) begin
         m_pend = 0;
         m_bump = 0;
         if (m_pcmd == 2'b01) begin
            if (m_fb()) m_bump = 1;
            else begin
               if (m_dir == 2'b00) m_row--;
               else if (m_dir == 2'b01) m_row++;
               else if (m_dir == 2'b10) m_col++;
               else m_col--;
               if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
         end else if (m_pcmd == 2'b10) m_dir = compass[(cidx(m_dir) + 3) % 4];
         else if (m_pcmd == 2'b11) m_dir = compass[(cidx(m_dir) + 1) % 4];
         m_busy = MOVE_TICKS;
      end else begin
         m_bump = 0;
         if (m_busy > 0) m_busy--;
         else if (pif.load_valid) begin
            if (pif.load_row >= 1 && pif.load_row <= ROWS && pif.load_col >= 1 && pif.load_col <= COLS) begin
               m_row = int'(pif.load_row); m_col = int'(pif.load_col); m_dir = pif.load_dir;
            end else m_anom = 1;
         end else if (pif.cmd_valid) begin
            m_pend = 1; m_pcmd = pif.cmd;
         end
      end
   endtask

   task automatic check_regs();
      chk("row", pif.robot_row, m_row);
      chk("col", pif.robot_column, m_col);
      chk("dir", pif.robot_orientation, m_dir);
      chk("bump", pif.bump, m_bump);
      chk("count", pif.move_count, m_cnt);
      chk("anomaly", pif.anomaly, m_anom);
   endtask

   task automatic check_comb();
      chk("cmd_ready", pif.cmd_ready, (!m_pend && m_busy == 0 && !pif.load_valid));
      chk("front_blocked", pif.front_blocked, m_fb());
   endtask

   // One clock cycle: inputs driven just after a rising edge, checked before and after the next one.
   task automatic cyc(input bit v, input logic [1:0] c, input bit w, input bit lv,
                      input logic [5:0] lr, input logic [5:0] lc, input logic [1:0] ld);
      pif.cmd_valid = v; pif.cmd = c; pif.wall_ahead = w;
      pif.load_valid = lv; pif.load_row = lr; pif.load_col = lc; pif.load_dir = ld;
      #1;
      check_comb();
      model_edge();
      @(posedge clock_50);
      #1;
      check_regs();
   endtask

   // Offer one command, then idle until cmd_ready returns; lo = cycles ready stayed low.
   task automatic issue(input logic [1:0] c, input bit w, output int lo);
      cyc(1'b1, c, w, 1'b0, 6'd0, 6'd0, 2'b00);
      lo = 0;
      while (pif.cmd_ready !== 1'b1 && lo < 20) begin
         lo++;
         cyc(1'b0, 2'b00, w, 1'b0, 6'd0, 6'd0, 2'b00);
      end
   endtask

   task automatic do_reset(input int cycles);
      reset_key = 1'b1;
      #1;
      model_reset();
      check_regs();
      repeat (cycles) @(posedge clock_50);
      #1;
      reset_key = 1'b0;
      check_regs();
   endtask

   initial begin
      int lo;
      reset_key = 1'b0;
      pif.cmd_valid = 1'b0; pif.cmd = 2'b00; pif.wall_ahead = 1'b0;
      pif.load_valid = 1'b0; pif.load_row = 6'd0; pif.load_col = 6'd0; pif.load_dir = 2'b00;
      model_reset();
      #2;

      // 1: reset
      do_reset(2);
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
      chk("t1_ready", pif.cmd_ready, 1);

      // 2: forward into the north border
      issue(2'b01, 1'b0, lo);
      chk("t2_spacing", lo, MOVE_TICKS + 1);
      chk("t2_row", pif.robot_row, 1);
      chk("t2_count", pif.move_count, 0);

      // 3: turn east and drive to the east border
      issue(2'b11, 1'b0, lo);
      chk("t3_dir", pif.robot_orientation, 2);
      for (int k = 0; k < 19; k++) begin
         issue(2'b01, 1'b0, lo);
         chk("t3_spacing", lo, MOVE_TICKS + 1);
      end
      chk("t3_col", pif.robot_column, 20);
      chk("t3_count", pif.move_count, 19);
      cyc(1'b1, 2'b01, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
      chk("t3_bump", pif.bump, 1);
      issue(2'b00, 1'b0, lo);
      chk("t3_col_hold", pif.robot_column, 20);

      // 4: turn south, wall blocks, then clear
      issue(2'b11, 1'b0, lo);
      chk("t4_dir", pif.robot_orientation, 1);
      issue(2'b01, 1'b1, lo);
      chk("t4_wall_row", pif.robot_row, 1);
      issue(2'b01, 1'b0, lo);
      chk("t4_row", pif.robot_row, 2);
      chk("t4_count", pif.move_count, 20);

      // 5: illegal then legal load (load beats a simultaneous command)
      cyc(1'b0, 2'b00, 1'b0, 1'b1, 6'd11, 6'd5, 2'b11);
      chk("t5_anomaly", pif.anomaly, 1);
      chk("t5_row_kept", pif.robot_row, 2);
      cyc(1'b1, 2'b01, 1'b0, 1'b1, 6'd10, 6'd20, 2'b01);
      chk("t5_load_row", pif.robot_row, 10);
      chk("t5_load_col", pif.robot_column, 20);
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
      chk("t5_no_accept", pif.cmd_ready, 1);
      chk("t5_anomaly_sticky", pif.anomaly, 1);

      // 6: reset in the second wait cycle drops the pending work
      cyc(1'b0, 2'b00, 1'b0, 1'b1, 6'd5, 6'd5, 2'b00);
      cyc(1'b1, 2'b01, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
      chk("t6_moved", pif.robot_row, 4);
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
      do_reset(2);
      chk("t6_row", pif.robot_row, 1);
      chk("t6_count", pif.move_count, 0);
      repeat (6) cyc(1'b0, 2'b00, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00);
      chk("t6_ready", pif.cmd_ready, 1);
      chk("t6_no_deferred", pif.robot_row, 1);

      // 7: randomized traffic, occasional resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset(1);
         end else begin
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                6'($urandom_range(0, 12)), 6'($urandom_range(0, 22)), 2'($urandom_range(0, 3)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
